// File: rtl/sipo_rx_ctrl_pkg.sv
// Shared SPI-style shift types: FSM state codes, shift-register op codes and a clog2 helper.
// Used by the receive controller and by the transmit side.
package sipo_rx_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'b00,
        OP_CLEAR = 2'b01,
        OP_SHIFT = 2'b10
    } sr_op_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sipo_rx_ctrl_if.sv
// Frame receiver bus: request/tick/data in, select/status/word out.
// SIPO_RX_OVERRUN_EN adds the sticky overrun flag ovr_o.
interface sipo_rx_ctrl_if #(
    parameter int Width = 16
);
    logic             start_i;
    logic             sample_i;
    logic             din_i;
    logic             cs_n_o;
    logic             busy_o;
    logic             valid_o;
    logic [Width-1:0] dout_o;
`ifdef SIPO_RX_OVERRUN_EN
    logic             ovr_o;

    modport master (output start_i, sample_i, din_i,
                    input  cs_n_o, busy_o, valid_o, dout_o, ovr_o);
    modport slave  (input  start_i, sample_i, din_i,
                    output cs_n_o, busy_o, valid_o, dout_o, ovr_o);
`else
    modport master (output start_i, sample_i, din_i,
                    input  cs_n_o, busy_o, valid_o, dout_o);
    modport slave  (input  start_i, sample_i, din_i,
                    output cs_n_o, busy_o, valid_o, dout_o);
`endif
endinterface

// File: rtl/sipo_reg.sv
// Width-bit MSB-first shift register (hold/clear/shift-left), one clock per op.
// No backpressure: the op is applied on every clock edge.
module sipo_reg
    import sipo_rx_ctrl_pkg::*;
#(
    parameter int Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  sr_op_t           op_i,
    input  logic             din_i,
    output logic [Width-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o <= '0;
        end else begin
            case (op_i)
                OP_CLEAR: q_o <= '0;
                OP_SHIFT: q_o <= {q_o[Width-2:0], din_i};
                default:  q_o <= q_o;
            endcase
        end
    end

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Serial frame receiver: cs_n_o falls 1 clk after start, valid_o pulses 1 clk after the last tick.
// No backpressure; start_i while busy is dropped (flagged on ovr_o under SIPO_RX_OVERRUN_EN).
module sipo_rx_ctrl
    import sipo_rx_ctrl_pkg::*;
#(
    parameter int Width = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    sipo_rx_ctrl_if.slave bus
);

    localparam int CntW = clog2(Width + 1);

    state_t           state;
    logic [CntW-1:0]  cnt;
    sr_op_t           sr_op;
    logic [Width-1:0] sr_q;
    logic [Width-1:0] next_word;
    logic             cs_n_q;
    logic             busy_q;
    logic             valid_q;
    logic [Width-1:0] dout_q;

    always_comb begin
        sr_op = OP_HOLD;
        if (state == ST_IDLE && bus.start_i) begin
            sr_op = OP_CLEAR;
        end else if (state == ST_SHIFT && bus.sample_i) begin
            sr_op = OP_SHIFT;
        end
    end

    // The final bit is folded in directly so dout_q lands on the same edge as the last shift.
    assign next_word = {sr_q[Width-2:0], bus.din_i};

    sipo_reg #(.Width(Width)) u_sipo_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .op_i  (sr_op),
        .din_i (bus.din_i),
        .q_o   (sr_q)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    valid_q <= 1'b0;
                    if (bus.start_i) begin
                        cnt    <= CntW'(Width);
                        state  <= ST_SHIFT;
                        cs_n_q <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (bus.sample_i) begin
                        cnt <= cnt - CntW'(1);
                        if (cnt == CntW'(1)) begin
                            dout_q  <= next_word;
                            valid_q <= 1'b1;
                            cs_n_q  <= 1'b1;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    cs_n_q  <= 1'b1;
                end
                default: begin
                    state   <= ST_IDLE;
                    cnt     <= '0;
                    cs_n_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    dout_q  <= '0;
                end
            endcase
        end
    end

    assign bus.cs_n_o  = cs_n_q;
    assign bus.busy_o  = busy_q;
    assign bus.valid_o = valid_q;
    assign bus.dout_o  = dout_q;

`ifdef SIPO_RX_OVERRUN_EN
    logic ovr_q;

    // Accepting a new frame clears the flag and takes priority over a same-edge set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovr_q <= 1'b0;
        end else if (state == ST_IDLE && bus.start_i) begin
            ovr_q <= 1'b0;
        end else if (bus.start_i && busy_q) begin
            ovr_q <= 1'b1;
        end
    end

    assign bus.ovr_o = ovr_q;
`endif

endmodule
